// File: rtl/banked_msg_ram_pkg.sv
// Shared types for the LDPC message memory: clear-sequencer states and default geometry.
package ldpc_mem_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_NUM_BANKS  = 4;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } clr_state_e;

endpackage

// File: rtl/banked_msg_ram_if.sv
// User-side bundle of the banked message RAM; per-bank fields are packed bank-major.
interface banked_msg_ram_if
    import ldpc_mem_pkg::*;
#(
    parameter int NUM_BANKS  = DEF_NUM_BANKS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                            chip_sel;
    logic                            clr_req;
    logic                            busy;
    logic [NUM_BANKS-1:0]            wr_en;
    logic [NUM_BANKS*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_BANKS*DATA_WIDTH-1:0] wr_data;
    logic [NUM_BANKS-1:0]            rd_en;
    logic [NUM_BANKS*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data;
    logic [NUM_BANKS-1:0]            rd_valid;

    modport master (
        output chip_sel, clr_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  busy, rd_data, rd_valid
    );

    modport slave (
        input  chip_sel, clr_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output busy, rd_data, rd_valid
    );

endinterface

// File: rtl/banked_msg_ram_bank.sv
// One 1R1W message bank: write on the edge, registered read one cycle later, optional
// same-address write-through; out-of-range writes are dropped and out-of-range reads return 0.
module msg_ram_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter bit BYPASS_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o
);

    localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_ok;
    logic                  rd_in_range;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;

    assign wr_ok       = wr_en_i && ({1'b0, wr_addr_i} < DEPTH_W);
    assign rd_in_range = {1'b0, rd_addr_i} < DEPTH_W;
    assign wr_idx      = wr_addr_i[IDX_W-1:0];
    assign rd_idx      = rd_addr_i[IDX_W-1:0];

    // Storage has no reset: the top-level clear sequencer zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_idx] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (rd_en_i) begin
            rd_valid_d = 1'b1;
            if (!rd_in_range) begin
                rd_data_d = '0;
            end else if (BYPASS_EN && wr_ok && (wr_addr_i == rd_addr_i)) begin
                rd_data_d = wr_data_i;
            end else begin
                rd_data_d = mem_q[rd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/banked_msg_ram.sv
// Multi-bank 1R1W message RAM with a clear sequencer that zeroes every bank after reset or on clr_req.
// Reads return one cycle after acceptance; user traffic is dropped while busy or when chip_sel is low.
module banked_msg_ram
    import ldpc_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int NUM_BANKS  = DEF_NUM_BANKS,
    parameter bit BYPASS_EN  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    banked_msg_ram_if.slave bus
);

    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(RAM_DEPTH - 1);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
    logic                  clearing;
    logic                  user_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Counter is one bit wider than the address so a full power-of-two depth ends cleanly.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    assign clearing = (state_q == ST_CLEAR);
    assign user_ok  = !clearing && bus.chip_sel;
    assign bus.busy = clearing;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic                  bank_wr_en;
        logic [ADDR_WIDTH-1:0] bank_wr_addr;
        logic [DATA_WIDTH-1:0] bank_wr_data;
        logic                  bank_rd_en;

        always_comb begin
            bank_wr_en   = user_ok && bus.wr_en[b];
            bank_wr_addr = bus.wr_addr[b*ADDR_WIDTH +: ADDR_WIDTH];
            bank_wr_data = bus.wr_data[b*DATA_WIDTH +: DATA_WIDTH];
            bank_rd_en   = user_ok && bus.rd_en[b];
            if (clearing) begin
                bank_wr_en   = 1'b1;
                bank_wr_addr = clr_cnt_q[ADDR_WIDTH-1:0];
                bank_wr_data = '0;
            end
        end

        msg_ram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .RAM_DEPTH  (RAM_DEPTH),
            .BYPASS_EN  (BYPASS_EN)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .wr_en_i    (bank_wr_en),
            .wr_addr_i  (bank_wr_addr),
            .wr_data_i  (bank_wr_data),
            .rd_en_i    (bank_rd_en),
            .rd_addr_i  (bus.rd_addr[b*ADDR_WIDTH +: ADDR_WIDTH]),
            .rd_data_o  (bus.rd_data[b*DATA_WIDTH +: DATA_WIDTH]),
            .rd_valid_o (bus.rd_valid[b])
        );
    end

endmodule
